// File: rtl/data_mem_responder.sv
// Data memory for the single-cycle RV32I core: word RAM with byte/half/word loads and stores.
// Stores commit at the request edge. Loads return via a one-cycle DM_valid pulse LATENCY edges after acceptance (LATENCY=1: the cycle right after acceptance).
// No backpressure on outputs; the core holds load until DM_valid, and loads/stores are only accepted while idle.
module data_mem_responder #(
  parameter int ADDRESS = 32,
  parameter int DATA    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               store,
  input  logic [ADDRESS-1:0] address,
  input  logic [DATA-1:0]    wdata,
  input  logic [2:0]         funct3,
  output logic               DM_valid,
  output logic [DATA-1:0]    rdata,
  output logic               misaligned
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             go_resp;
  logic [IDX_W+1:0] cap_addr;
  logic [2:0]       cap_f3;
  logic [DATA-1:0]  mem [DEPTH];

  // Upper address bits alias onto the RAM and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, address[ADDRESS-1:IDX_W+2]};

  // Natural alignment: halves need bit 0 clear, words (and reserved encodings) need both clear.
  function automatic logic is_mis(input logic [2:0] f, input logic [1:0] a);
    case (f[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  // Response read address: with LATENCY=1 the read happens at the acceptance edge itself.
  logic [IDX_W+1:0] rd_a;
  logic [2:0]       rd_f3;
  logic [DATA-1:0]  rd_word;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [DATA-1:0]  ld_data;
  logic             ld_mis;

  // Select, extend and alignment-gate the load result.
  always_comb begin
    rd_a     = (state == IDLE) ? address[IDX_W+1:0] : cap_addr;
    rd_f3    = (state == IDLE) ? funct3 : cap_f3;
    rd_word  = mem[rd_a[IDX_W+1:2]];
    byte_sel = rd_word[{rd_a[1:0], 3'b000} +: 8];
    half_sel = rd_a[1] ? rd_word[31:16] : rd_word[15:0];
    ld_mis   = is_mis(rd_f3, rd_a[1:0]);
    case (rd_f3)
      3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ld_data = {24'h000000, byte_sel};
      3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  ld_data = {16'h0000, half_sel};
      default: ld_data = rd_word;
    endcase
    if (ld_mis) begin
      ld_data = '0;
    end
  end

  // Next-state logic: load acceptance, latency countdown, single response cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    go_resp   = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
            go_resp   = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          go_resp   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Store path: only from IDLE, a coincident load wins, misaligned stores are suppressed.
  logic            st_acc, st_mis, wr_en;
  logic [3:0]      be;
  logic [DATA-1:0] wd;

  // Byte enables and lane-replicated write data per access size.
  always_comb begin
    st_acc = (state == IDLE) && store && !load;
    st_mis = is_mis(funct3, address[1:0]);
    wr_en  = st_acc && !st_mis;
    be     = 4'b1111;
    wd     = wdata;
    case (funct3[1:0])
      2'b00: begin
        be = 4'b0001 << address[1:0];
        wd = {4{wdata[7:0]}};
      end
      2'b01: begin
        be = address[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = wdata;
      end
    endcase
  end

  // RAM write; contents survive reset, but no write commits while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[address[IDX_W+1:2]][8*i +: 8] <= wd[8*i +: 8];
        end
      end
    end
  end

  // Capture the request when a load is accepted from IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_addr <= '0;
      cap_f3   <= '0;
    end else if (state == IDLE && load) begin
      cap_addr <= address[IDX_W+1:0];
      cap_f3   <= funct3;
    end
  end

  // State register and registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      DM_valid   <= 1'b0;
      rdata      <= '0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      DM_valid   <= go_resp;
      rdata      <= go_resp ? ld_data : '0;
      misaligned <= (go_resp && ld_mis) || (st_acc && st_mis);
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the single-cycle RV32I core, on the other end of the load/DM_valid handshake that stalls the PC.
- Accepts load and store requests from the core and holds an internal word-organised RAM.
- Stores complete in one cycle with no stall.
- Loads take a fixed, parameterised latency. DM_valid pulses for one cycle with the aligned, sign/zero-extended load data, which releases the PC stall.

Parameters:
- ADDRESS, 32, byte-address width.
- DATA, 32, data width (fixed at 32 for RV32I).
- DEPTH, 1024, RAM depth in 32-bit words (power of two).
- LATENCY, 2, edges from load acceptance to DM_valid assertion (legal range 1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- load  in  1  load request; held high by the core until DM_valid.
- store  in  1  store request, single cycle.
- address  in  ADDRESS  byte address.
- wdata  in  DATA  store data (low bytes used for SB/SH).
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- DM_valid  out  1  one-cycle load-complete pulse.
- rdata  out  DATA  load result; valid only when DM_valid is high.
- misaligned  out  1  one-cycle pulse flagging a misaligned access.

Behaviour:
- Reset: one clock, synchronous active-low. On any edge with rst=0:
  - state goes to IDLE, counter=0, DM_valid=0, rdata=0, misaligned=0.
  - RAM contents are not cleared.
  - A pending load is aborted with no DM_valid.
- Word index = address[log2(DEPTH)+1:2]. Upper address bits are ignored (the RAM aliases).
- FSM states: IDLE, WAIT, RESP.
  - IDLE, load=1 at an edge: capture address and funct3, set counter=LATENCY-1, go to WAIT. When LATENCY=1, go directly to RESP.
  - WAIT: counter decrements each edge. At counter=0, go to RESP.
  - RESP: DM_valid=1 and rdata are registered outputs for exactly this cycle. Next edge goes to IDLE.
  - Net effect: DM_valid is high during the cycle after edge E0+LATENCY, where E0 is the acceptance edge.
- load held high in RESP is not re-accepted. The core's next load is accepted only from IDLE, so it starts at least one cycle after DM_valid.
- Load data uses captured address bits [1:0]:
  - LB/LBU: select byte, then sign-extend or zero-extend.
  - LH/LHU: select half using address[1], then extend.
  - LW: full word.
  - Reserved funct3 (011, 110, 111): treated as LW.
- Stores are accepted only in IDLE. The write commits at the same edge, with byte enables per funct3 and address[1:0].
  - SB writes wdata[7:0] to the selected byte lane.
  - SH writes wdata[15:0] to the selected half.
  - SW writes the whole word.
  - Store in WAIT/RESP is a protocol violation: ignored, no write.
- Simultaneous load and store in IDLE: load wins, store is dropped.
- Read-after-write: a store at edge E and a load accepted at E+1 return the new data.
- Misalignment rules:
  - Misaligned = H/HU with address[0]=1, or W with address[1:0]≠0.
  - Misaligned store: write suppressed; misaligned pulses in the next cycle.
  - Misaligned load: still completes with the normal latency; rdata=0; misaligned pulses with DM_valid.
- Reads of the RAM occur at the RESP transition edge, so data reflects all stores committed up to acceptance.

Test Plan:
- Reset mid-load:
  - Stimulus: LATENCY=2; accept a load; assert rst=0 at acceptance+1 edge.
  - Required: DM_valid never asserts; state is IDLE; rdata=0; next load completes normally.
- SW then LW, no stall on store:
  - Stimulus: store=1, funct3=010, address=0x10, wdata=0xDEADBEEF (one cycle); then load funct3=010, address=0x10 held.
  - Required: DM_valid high exactly 3 cycles after the load is first presented (LATENCY=2); rdata=0xDEADBEEF.
- Sub-word loads:
  - Stimulus: word at 0x20 = 0x80F17F01.
  - Required:
    - LB @0x23 gives 0xFFFFFF80.
    - LBU @0x23 gives 0x00000080.
    - LH @0x22 gives 0xFFFF80F1.
    - LHU @0x22 gives 0x000080F1.
    - LB @0x21 gives 0x0000007F.
- Byte-lane store:
  - Stimulus: word 0x30 = 0x11223344; SB @0x31 wdata=0xAA; SH @0x32 wdata=0xBBCC.
  - Required: LW @0x30 = 0xBBCCAA44.
- Misaligned accesses:
  - Stimulus: SW @0x41 wdata=0x12345678; then LH @0x43.
  - Required:
    - For the store: misaligned pulse, word 0x40 unchanged.
    - For the load: DM_valid with rdata=0 and misaligned=1 in the same cycle.
- Back-to-back loads with load held continuously:
  - Stimulus: load held high across two requests (LATENCY=1), addresses 0x50 then 0x54.
  - Required: DM_valid pulses are separated by exactly one idle cycle; each rdata matches its address.
  - Also required: a simultaneous store during WAIT is ignored.
